stopwatch_ctrl: RTL and testbench

//  Front-end control stage for the stopwatch: conditions raw board buttons/switch, runs the

---
 rtl/stopwatch_pkg.sv | 38 +++
 rtl/btn_debounce.sv | 62 ++++++
 rtl/stopwatch_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control front end.
//   mode_e        : operating mode of the control FSM
//   ADJ_SEL_NONE  : adj_sel value meaning "no digit write this cycle"
//   DIGIT_*       : digit indices (seconds right/left, minutes right/left)
//   LIM_*         : highest legal value of a digit
//   digit_limit() : wrap limit for a given digit index
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_ADJUST  = 2'd2
    } mode_e;

    localparam logic [2:0] ADJ_SEL_NONE = 3'd5;

    localparam logic [1:0] DIGIT_SEC_R = 2'd0;
    localparam logic [1:0] DIGIT_SEC_L = 2'd1;
    localparam logic [1:0] DIGIT_MIN_R = 2'd2;
    localparam logic [1:0] DIGIT_MIN_L = 2'd3;

    localparam logic [3:0] LIM_SEC_L   = 4'd5;
    localparam logic [3:0] LIM_DEFAULT = 4'd9;

    // Tens-of-seconds digit wraps at 5, every other digit at 9.
    function automatic logic [3:0] digit_limit(input logic [1:0] sel);
        logic [3:0] lim;
        case (sel)
            DIGIT_SEC_L: lim = LIM_SEC_L;
            DIGIT_SEC_R,
            DIGIT_MIN_R,
            DIGIT_MIN_L: lim = LIM_DEFAULT;
            default:     lim = LIM_DEFAULT;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Conditions one raw board input.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (level returns to 0 = released)
//   raw   in  asynchronous pin
//   level out debounced level, changes only after DB_CYCLES consecutive
//             synchronized samples that disagree with the current level
//   press out one-cycle pulse, high in the same cycle level rises
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive disagreeing samples; flip the level on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= '0;
                level_r <= sync2_r;
                press_r <= sync2_r;
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
                press_r <= 1'b0;
            end
        end else begin
            cnt_r   <= '0;
            press_r <= 1'b0;
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end control: conditions the board buttons and switch,
// runs the PAUSED/RUNNING/ADJUST mode FSM and drives the counter controls.
// Optional build macro: STOPWATCH_AUTO_REPEAT_EN enables btn_inc auto-repeat.
//   clk, rst_n             clock, asynchronous active-low reset
//   btn_pause/reset/sel/inc raw pushbuttons
//   sw_adj                 raw slide switch, 1 = adjust mode
//   rst                    one-cycle clear pulse to the counter
//   paused                 1 = counter must not advance
//   adj                    1 = adjust mode
//   adj_sel                digit write select 0..3, 5 = no write
//   adj_val                value written when adj_sel != 5 (holds otherwise)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       sw_adj,
    output logic       rst,
    output logic       paused,
    output logic       adj,
    output logic [2:0] adj_sel,
    output logic [3:0] adj_val
);

    logic pause_press_s, reset_press_s, sel_press_s, inc_press_s, sw_press_s;
    logic pause_lvl_s, reset_lvl_s, sel_lvl_s, inc_lvl_s, sw_lvl_s;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk(clk), .rst_n(rst_n), .raw(btn_pause), .level(pause_lvl_s), .press(pause_press_s));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
        .clk(clk), .rst_n(rst_n), .raw(btn_reset), .level(reset_lvl_s), .press(reset_press_s));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
        .clk(clk), .rst_n(rst_n), .raw(btn_sel), .level(sel_lvl_s), .press(sel_press_s));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk(clk), .rst_n(rst_n), .raw(btn_inc), .level(inc_lvl_s), .press(inc_press_s));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sw (
        .clk(clk), .rst_n(rst_n), .raw(sw_adj), .level(sw_lvl_s), .press(sw_press_s));

    // Only the levels of sw_adj/btn_inc and the presses of the buttons matter.
    logic unused_lvl_s;
    assign unused_lvl_s = ^{pause_lvl_s, reset_lvl_s, sel_lvl_s, sw_press_s};

    mode_e      state_r, state_s;
    logic [1:0] sel_r;
    logic [3:0] d_r [4];
    logic       rst_r, paused_r, adj_r;
    logic [2:0] adj_sel_r;
    logic [3:0] adj_val_r;

    logic       in_adj_s;
    logic       hold_ok_s;
    logic       rep_fire_s;
    logic       inc_ev_s;
    logic [3:0] cur_s;
    logic [3:0] nv_s;

    // Mode transitions; the switch dominates, pause is ignored in ADJUST.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_PAUSED: begin
                if (sw_lvl_s) begin
                    state_s = ST_ADJUST;
                end else if (pause_press_s) begin
                    state_s = ST_RUNNING;
                end else begin
                    state_s = ST_PAUSED;
                end
            end
            ST_RUNNING: begin
                if (sw_lvl_s) begin
                    state_s = ST_ADJUST;
                end else if (pause_press_s) begin
                    state_s = ST_PAUSED;
                end else begin
                    state_s = ST_RUNNING;
                end
            end
            ST_ADJUST: begin
                if (sw_lvl_s) begin
                    state_s = ST_ADJUST;
                end else begin
                    state_s = ST_PAUSED;
                end
            end
            default: state_s = ST_PAUSED;
        endcase
    end

    // Increment event qualification and the wrapped next digit value.
    // Writes need the switch still high (a falling switch cancels the write)
    // and lose against a simultaneous reset press.
    always_comb begin
        in_adj_s  = (state_r == ST_ADJUST);
        hold_ok_s = in_adj_s && sw_lvl_s && inc_lvl_s && !reset_press_s;
        inc_ev_s  = 1'b0;
        if (in_adj_s && sw_lvl_s && !reset_press_s) begin
            inc_ev_s = inc_press_s || rep_fire_s;
        end else begin
            inc_ev_s = 1'b0;
        end
        cur_s = d_r[sel_r];
        if (cur_s == digit_limit(sel_r)) begin
            nv_s = 4'd0;
        end else begin
            nv_s = cur_s + 4'd1;
        end
    end

`ifdef STOPWATCH_AUTO_REPEAT_EN
    // rep_cnt_r counts cycles since the last inc event while held; 0 = idle.
    logic [31:0] rep_cnt_r;
    logic        rep_first_r;
    logic [31:0] rep_lim_s;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_CYCLES.
    always_comb begin
        if (rep_first_r) begin
            rep_lim_s = 32'(REPEAT_DELAY);
        end else begin
            rep_lim_s = 32'(REPEAT_CYCLES);
        end
        rep_fire_s = hold_ok_s && (rep_cnt_r != 32'd0) && (rep_cnt_r == rep_lim_s);
    end

    // Repeat timer: armed by a press, cleared on release, mode exit or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_r   <= 32'd0;
            rep_first_r <= 1'b1;
        end else if (!hold_ok_s) begin
            rep_cnt_r   <= 32'd0;
            rep_first_r <= 1'b1;
        end else if (inc_press_s) begin
            rep_cnt_r   <= 32'd1;
            rep_first_r <= 1'b1;
        end else if (rep_fire_s) begin
            rep_cnt_r   <= 32'd1;
            rep_first_r <= 1'b0;
        end else if (rep_cnt_r != 32'd0) begin
            rep_cnt_r   <= rep_cnt_r + 32'd1;
        end else begin
            rep_cnt_r   <= rep_cnt_r;
        end
    end
`else
    logic unused_rep_s;
    assign unused_rep_s = ^{hold_ok_s, REPEAT_DELAY, REPEAT_CYCLES, inc_lvl_s};
    assign rep_fire_s   = 1'b0;
`endif

    // Mode register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_PAUSED;
        end else begin
            state_r <= state_s;
        end
    end

    // Digit select; retained across mode changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= DIGIT_SEC_R;
        end else if (in_adj_s && sel_press_s) begin
            sel_r <= sel_r + 2'd1;
        end else begin
            sel_r <= sel_r;
        end
    end

    // Shadow digits: cleared by the reset button, updated by inc events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                d_r[i] <= 4'd0;
            end
        end else if (reset_press_s) begin
            for (int i = 0; i < 4; i++) begin
                d_r[i] <= 4'd0;
            end
        end else if (inc_ev_s) begin
            d_r[sel_r] <= nv_s;
        end else begin
            d_r[sel_r] <= d_r[sel_r];
        end
    end

    // Registered counter controls; paused/adj follow the next mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_r     <= 1'b0;
            paused_r  <= 1'b1;
            adj_r     <= 1'b0;
            adj_sel_r <= ADJ_SEL_NONE;
            adj_val_r <= 4'd0;
        end else begin
            rst_r    <= reset_press_s;
            paused_r <= (state_s != ST_RUNNING);
            adj_r    <= (state_s == ST_ADJUST);
            if (inc_ev_s) begin
                adj_sel_r <= {1'b0, sel_r};
                adj_val_r <= nv_s;
            end else begin
                adj_sel_r <= ADJ_SEL_NONE;
                adj_val_r <= adj_val_r;
            end
        end
    end

    assign rst     = rst_r;
    assign paused  = paused_r;
    assign adj     = adj_r;
    assign adj_sel = adj_sel_r;
    assign adj_val = adj_val_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DB_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_CYCLES=8). A cycle reference model built from the behavioural
// rules is compared on every clock; table entries and hand sequences add
// targeted expectations.
module tb_stopwatch_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RC = 8;
    localparam int B_PAUSE = 0;
    localparam int B_RESET = 1;
    localparam int B_SEL   = 2;
    localparam int B_INC   = 3;
    localparam int B_SW    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] raw_v = 5'd0;
    logic       rst, paused, adj;
    logic [2:0] adj_sel;
    logic [3:0] adj_val;

    stopwatch_ctrl #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_pause(raw_v[B_PAUSE]), .btn_reset(raw_v[B_RESET]), .btn_sel(raw_v[B_SEL]),
        .btn_inc(raw_v[B_INC]), .sw_adj(raw_v[B_SW]),
        .rst(rst), .paused(paused), .adj(adj), .adj_sel(adj_sel), .adj_val(adj_val));

    // 100 MHz clock.
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state.
    logic [4:0] hist[$];
    logic [4:0] m_lvl, pend_prs, pend_lvl;
    int   m_mode;   // 0 paused, 1 running, 2 adjust
    int   m_dig[4];
    int   m_sel;
    logic m_rst, m_paused, m_adj;
    logic [2:0] m_adj_sel;
    logic [3:0] m_adj_val;
    bit   rep_on;
    int   rep_t;

    // Log of DUT writes.
    int         wr_t[$];
    logic [3:0] wr_v[$];
    logic [2:0] wr_s[$];
    int         rst_hi;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 6; i++) hist.push_back(5'd0);
        m_lvl = 5'd0; pend_prs = 5'd0; pend_lvl = 5'd0;
        m_mode = 0; m_sel = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_rst = 1'b0; m_paused = 1'b1; m_adj = 1'b0; m_adj_sel = 3'd5; m_adj_val = 4'd0;
        rep_on = 1'b0; rep_t = 0;
    endtask

    // Apply the events the conditioners delivered on the previous clock.
    task automatic top_update();
        bit in_adj, hold_ok, fire;
        int lim, nv;
        in_adj  = (m_mode == 2);
        hold_ok = in_adj && pend_lvl[B_SW] && pend_lvl[B_INC] && !pend_prs[B_RESET];
        fire    = 1'b0;
`ifdef STOPWATCH_AUTO_REPEAT_EN
        if (pend_prs[B_INC] && hold_ok) begin
            rep_on = 1'b1; rep_t = 0;
        end else if (rep_on && hold_ok) begin
            rep_t++;
            fire = (rep_t == RD) || (rep_t > RD && ((rep_t - RD) % RC) == 0);
        end else begin
            rep_on = 1'b0;
        end
`endif
        m_rst = pend_prs[B_RESET];
        m_adj_sel = 3'd5;
        if (in_adj && pend_lvl[B_SW] && !pend_prs[B_RESET] && (pend_prs[B_INC] || fire)) begin
            lim = (m_sel == 1) ? 5 : 9;
            nv  = (m_dig[m_sel] == lim) ? 0 : m_dig[m_sel] + 1;
            m_dig[m_sel] = nv;
            m_adj_sel = 3'(m_sel);
            m_adj_val = 4'(nv);
        end
        if (pend_prs[B_RESET]) for (int i = 0; i < 4; i++) m_dig[i] = 0;
        if (in_adj && pend_prs[B_SEL]) m_sel = (m_sel + 1) % 4;
        if (pend_lvl[B_SW]) m_mode = 2;
        else if (m_mode == 2) m_mode = 0;
        else if (pend_prs[B_PAUSE]) m_mode = 1 - m_mode;
        m_paused = (m_mode != 1);
        m_adj    = (m_mode == 2);
    endtask

    // A level is accepted once the DB synchronized samples (2 clocks late) all disagree.
    task automatic model_edge();
        logic [4:0] prs;
        hist.push_front(raw_v);
        if (hist.size() > 6) void'(hist.pop_back());
        top_update();
        prs = 5'd0;
        for (int i = 0; i < 5; i++) begin
            bit flip = 1'b1;
            for (int k = 2; k < 2 + DB; k++) if (hist[k][i] == m_lvl[i]) flip = 1'b0;
            if (flip) begin
                m_lvl[i] = ~m_lvl[i];
                prs[i]   = m_lvl[i];
            end
        end
        pend_prs = prs;
        pend_lvl = m_lvl;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("outputs{rst,paused,adj,adj_sel,adj_val}", {6'd0, rst, paused, adj, adj_sel, adj_val},
            {6'd0, m_rst, m_paused, m_adj, m_adj_sel, m_adj_val});
        if (adj_sel !== 3'd5) begin
            wr_t.push_back(cyc); wr_v.push_back(adj_val); wr_s.push_back(adj_sel);
        end
        if (rst === 1'b1) rst_hi++;
    endtask

    task automatic press(input int b);
        raw_v[b] = 1'b1; repeat (8) tick();
        raw_v[b] = 1'b0; repeat (8) tick();
    endtask

    typedef struct {
        int         btn;
        logic       sw;
        logic       e_paused;
        logic       e_adj;
        logic [3:0] e_val;
        int         e_nwr;
        logic [2:0] e_wsel;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(int b, logic s, logic p, logic a, logic [3:0] v, int n, logic [2:0] ws);
        vec_t r;
        r.btn = b; r.sw = s; r.e_paused = p; r.e_adj = a; r.e_val = v; r.e_nwr = n; r.e_wsel = ws;
        return r;
    endfunction

    initial begin
        int w0, r0, ok;
        int exp_off[$];
        logic [3:0] seq3 [7];

        // Vectors: press btn with sw at level -> expected paused, adj, adj_val, #writes, write sel.
        tbl.push_back(mk(B_PAUSE, 1'b0, 1'b0, 1'b0, 4'd0, 0, 3'd5));
        tbl.push_back(mk(B_PAUSE, 1'b0, 1'b1, 1'b0, 4'd0, 0, 3'd5));
        tbl.push_back(mk(B_SEL,   1'b1, 1'b1, 1'b1, 4'd0, 0, 3'd5));
        seq3 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
        for (int i = 0; i < 7; i++) tbl.push_back(mk(B_INC, 1'b1, 1'b1, 1'b1, seq3[i], 1, 3'd1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(B_SEL, 1'b1, 1'b1, 1'b1, 4'd1, 0, 3'd5));
        for (int i = 1; i <= 10; i++) tbl.push_back(mk(B_INC, 1'b1, 1'b1, 1'b1, 4'(i % 10), 1, 3'd0));
        tbl.push_back(mk(B_PAUSE, 1'b1, 1'b1, 1'b1, 4'd0, 0, 3'd5));
        tbl.push_back(mk(B_INC,   1'b0, 1'b1, 1'b0, 4'd0, 0, 3'd5));

        // Reset state.
        model_reset();
        rst_hi = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {6'd0, rst, paused, adj, adj_sel, adj_val}, {6'd0, 1'b0, 1'b1, 1'b0, 3'd5, 4'd0});
        rst_n = 1'b1;

        // Table-driven mode, select and increment behaviour.
        for (int e = 0; e < tbl.size(); e++) begin
            raw_v[B_SW] = tbl[e].sw;
            w0 = wr_t.size();
            repeat (8) tick();
            press(tbl[e].btn);
            chk("tbl_paused", {15'd0, paused}, {15'd0, tbl[e].e_paused});
            chk("tbl_adj", {15'd0, adj}, {15'd0, tbl[e].e_adj});
            chk("tbl_adj_val", {12'd0, adj_val}, {12'd0, tbl[e].e_val});
            chk("tbl_nwrites", 16'(wr_t.size() - w0), 16'(tbl[e].e_nwr));
            if (tbl[e].e_nwr != 0 && wr_s.size() > w0)
                chk("tbl_wsel", {13'd0, wr_s[wr_s.size() - 1]}, {13'd0, tbl[e].e_wsel});
        end

        // Bouncing reset button: exactly one single-cycle pulse.
        r0 = rst_hi;
        for (int i = 0; i < 5; i++) begin
            raw_v[B_RESET] = (i % 2 == 0); repeat (2) tick();
        end
        raw_v[B_RESET] = 1'b1; repeat (10) tick();
        raw_v[B_RESET] = 1'b0; repeat (10) tick();
        chk("bounce_rst_cycles", 16'(rst_hi - r0), 16'd1);

        // Reset and inc in the same cycle: reset wins, digits cleared.
        raw_v[B_SW] = 1'b1; repeat (8) tick();
        press(B_INC);
        chk("pre_inc_val", {12'd0, adj_val}, 16'd1);
        r0 = rst_hi; w0 = wr_t.size();
        raw_v[B_RESET] = 1'b1; raw_v[B_INC] = 1'b1; repeat (8) tick();
        raw_v[B_RESET] = 1'b0; raw_v[B_INC] = 1'b0; repeat (8) tick();
        chk("rst_inc_rst", 16'(rst_hi - r0), 16'd1);
        chk("rst_inc_nowrite", 16'(wr_t.size() - w0), 16'd0);
        press(B_INC);
        chk("after_rst_val", {12'd0, adj_val}, 16'd1);

        // Held inc: repeat timing relative to the first write.
`ifdef STOPWATCH_AUTO_REPEAT_EN
        exp_off = '{0, 20, 28, 36};
`else
        exp_off = '{0};
`endif
        w0 = wr_t.size();
        raw_v[B_INC] = 1'b1; repeat (41) tick();
        raw_v[B_INC] = 1'b0; repeat (30) tick();
        chk("hold_nwrites", 16'(wr_t.size() - w0), 16'(exp_off.size()));
        if (wr_t.size() - w0 == exp_off.size()) begin
            for (int i = 0; i < exp_off.size(); i++) begin
                chk("hold_offset", 16'(wr_t[w0 + i] - wr_t[w0]), 16'(exp_off[i]));
                chk("hold_value", {12'd0, wr_v[w0 + i]}, 16'(2 + i));
            end
        end

        // Asynchronous reset in the middle of an rst pulse.
        raw_v[B_RESET] = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            tick();
            if (rst === 1'b1) ok = 1;
        end
        chk("rst_pulse_seen", 16'(ok), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {6'd0, rst, paused, adj, adj_sel, adj_val}, {6'd0, 1'b0, 1'b1, 1'b0, 3'd5, 4'd0});
        raw_v = 5'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // Random stimulus against the reference model.
        for (int t = 0; t < 4000; t++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) raw_v[b] = ~raw_v[b];
            if ($urandom_range(0, 59) == 0) raw_v[B_SW] = ~raw_v[B_SW];
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
